// File: rtl/sps_gate_actuator.sv
// Barrier-gate driver: raises on open requests, tracks passage credits, reverses for safety, latches faults.
// Optional blinking warn_lamp is compiled in when SPS_GATE_WARN_EN is defined.
module sps_gate_actuator #(
  parameter int HOLD_CYCLES  = 8,
  parameter int MOVE_TIMEOUT = 64,
`ifdef SPS_GATE_WARN_EN
  parameter int BLINK_PERIOD = 4,
`endif
  parameter int WAIT_TIMEOUT = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       open_req,
  input  logic       up_limit,
  input  logic       down_limit,
  input  logic       car_present,
  output logic       motor_up,
  output logic       motor_down,
  output logic       gate_busy,
  output logic       pass_done,
  output logic       fault,
  output logic [1:0] credit,
  output logic       warn_lamp
);

  localparam int MAX_HM = (HOLD_CYCLES > MOVE_TIMEOUT) ? HOLD_CYCLES : MOVE_TIMEOUT;
  localparam int MAX_T  = (MAX_HM > WAIT_TIMEOUT) ? MAX_HM : WAIT_TIMEOUT;
  localparam int TW     = $clog2(MAX_T) + 1;

  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT, CLOSED, RAISING, OPEN_WAIT, PASSING, HOLD, LOWERING, FAULT
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [1:0]    credit_nxt;
  logic          pass_nxt;

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    pass_nxt   = 1'b0;

    if (state != FAULT && open_req && credit != 2'd3)
      credit_nxt = credit + 2'd1;

    case (state)
      INIT:      state_nxt = down_limit ? CLOSED : LOWERING;
      CLOSED:    if (open_req) state_nxt = RAISING;
      RAISING: begin
        if (up_limit)                state_nxt = OPEN_WAIT;
        else if (timer == MOVE_LAST) state_nxt = FAULT;
      end
      OPEN_WAIT: begin
        if (car_present) state_nxt = PASSING;
        else if (timer == WAIT_LAST) begin
          state_nxt  = LOWERING;
          credit_nxt = 2'd0;
        end
      end
      // A request arriving with the passage cancels the decrement.
      PASSING: begin
        if (!car_present) begin
          pass_nxt = 1'b1;
          if (open_req)           credit_nxt = credit;
          else if (credit != 2'd0) credit_nxt = credit - 2'd1;
          else                     credit_nxt = 2'd0;
          state_nxt = (credit_nxt != 2'd0) ? OPEN_WAIT : HOLD;
        end
      end
      HOLD: begin
        if (car_present)             state_nxt = PASSING;
        else if (open_req)           state_nxt = OPEN_WAIT;
        else if (timer == HOLD_LAST) state_nxt = LOWERING;
      end
      LOWERING: begin
        if (car_present || open_req) state_nxt = RAISING;
        else if (down_limit)         state_nxt = CLOSED;
        else if (timer == MOVE_LAST) state_nxt = FAULT;
      end
      default: state_nxt = FAULT;
    endcase

    if (up_limit && down_limit && state != INIT)
      state_nxt = FAULT;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      timer      <= '0;
      credit     <= 2'd0;
      pass_done  <= 1'b0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      gate_busy  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      pass_done  <= pass_nxt;
      motor_up   <= (state_nxt == RAISING);
      motor_down <= (state_nxt == LOWERING);
      gate_busy  <= !(state_nxt inside {CLOSED, FAULT});
      fault      <= (state_nxt == FAULT);
      if (state_nxt != state)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + TW'(1);
    end
  end

`ifdef SPS_GATE_WARN_EN
  localparam int BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

  logic [BW-1:0] blink_cnt;

  // The blink phase carries across moves between the motion states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      warn_lamp <= 1'b0;
    end else if (state_nxt == FAULT) begin
      blink_cnt <= '0;
      warn_lamp <= 1'b1;
    end else if (state_nxt inside {RAISING, LOWERING, HOLD}) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        warn_lamp <= ~warn_lamp;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      warn_lamp <= 1'b0;
    end
  end
`else
  assign warn_lamp = 1'b0;
`endif

endmodule
